// File: rtl/intersection_phase_scheduler_pkg.sv
// traffic_pkg: light codes and phase codes shared with the signal-head drivers
package traffic_pkg;
  typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} light_t;
  typedef enum logic [2:0] {
    ALLRED_INIT = 3'd0,
    NS_GREEN    = 3'd1,
    NS_YELLOW   = 3'd2,
    ALLRED      = 3'd3,
    PED_WALK    = 3'd4,
    EW_GREEN    = 3'd5,
    EW_YELLOW   = 3'd6
  } phase_t;
endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// intersection_phase_scheduler_if: sensor inputs and signal-head outputs of the scheduler
interface intersection_phase_scheduler_if;
  import traffic_pkg::*;
  logic car_ns, car_ew, ped_req, ped_ack, walk;
  light_t light_ns, light_ew;
  phase_t phase;
  modport master(output car_ns, car_ew, ped_req, input ped_ack, light_ns, light_ew, walk, phase);
  modport slave(input car_ns, car_ew, ped_req, output ped_ack, light_ns, light_ew, walk, phase);
endinterface

// File: rtl/intersection_phase_scheduler_timer.sv
// phase_timer: saturating cycle counter, cleared on every phase change
module phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (en && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: NS/EW/pedestrian phase sequencing with all-red clearance
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN   = 8,
  parameter int unsigned GREEN_MAX   = 15,
  parameter int unsigned YELLOW_TIME = 4,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned WALK_TIME   = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic clk,
  input logic rst_n,
  intersection_phase_scheduler_if.slave bus
);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t G_MIN = cnt_t'(GREEN_MIN - 1);
  localparam cnt_t G_MAX = cnt_t'(GREEN_MAX - 1);
  localparam cnt_t Y_END = cnt_t'(YELLOW_TIME - 1);
  localparam cnt_t R_END = cnt_t'(ALLRED_TIME - 1);
  localparam cnt_t W_END = cnt_t'(WALK_TIME - 1);
  localparam int unsigned T_MAX = (1 << CNT_W) - 1;
  if (GREEN_MIN > GREEN_MAX || GREEN_MIN == 0 || YELLOW_TIME == 0 || ALLRED_TIME == 0 ||
      WALK_TIME == 0 || GREEN_MAX > T_MAX || YELLOW_TIME > T_MAX || ALLRED_TIME > T_MAX ||
      WALK_TIME > T_MAX) begin : g_param_check
    $error("intersection_phase_scheduler: illegal timing parameters");
  end
  phase_t state, nxt;
  cnt_t timer;
  logic ped_pending, next_ew, walk_entry;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(nxt != state),
    .en(1'b1),
    .count(timer)
  );
  // Green yields only when the other road or the crossing is waiting.
  always_comb begin
    nxt = state;
    case (state)
      ALLRED_INIT: if (timer == R_END) nxt = ped_pending ? PED_WALK : NS_GREEN;
      NS_GREEN:    if ((bus.car_ew || ped_pending) &&
                       ((timer >= G_MIN && !bus.car_ns) || timer >= G_MAX)) nxt = NS_YELLOW;
      NS_YELLOW:   if (timer == Y_END) nxt = ALLRED;
      ALLRED:      if (timer == R_END) nxt = ped_pending ? PED_WALK : next_ew ? EW_GREEN : NS_GREEN;
      PED_WALK:    if (timer == W_END) nxt = next_ew ? EW_GREEN : NS_GREEN;
      EW_GREEN:    if ((bus.car_ns || ped_pending) &&
                       ((timer >= G_MIN && !bus.car_ew) || timer >= G_MAX)) nxt = EW_YELLOW;
      EW_YELLOW:   if (timer == Y_END) nxt = ALLRED;
      default:     nxt = ALLRED_INIT;
    endcase
  end
  assign walk_entry = nxt == PED_WALK && state != PED_WALK;
  // Outputs are registered from the next state so they change on the entering edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= ALLRED_INIT;
      ped_pending  <= 1'b0;
      next_ew      <= 1'b0;
      bus.light_ns <= RED;
      bus.light_ew <= RED;
      bus.walk     <= 1'b0;
      bus.ped_ack  <= 1'b0;
      bus.phase    <= ALLRED_INIT;
    end else begin
      state        <= nxt;
      ped_pending  <= bus.ped_req | (ped_pending & !walk_entry);
      if ((state == NS_YELLOW || state == EW_YELLOW) && nxt == ALLRED) next_ew <= state == NS_YELLOW;
      bus.light_ns <= nxt == NS_GREEN ? GREEN : nxt == NS_YELLOW ? YELLOW : RED;
      bus.light_ew <= nxt == EW_GREEN ? GREEN : nxt == EW_YELLOW ? YELLOW : RED;
      bus.walk     <= nxt == PED_WALK;
      bus.ped_ack  <= walk_entry;
      bus.phase    <= nxt;
    end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: scoreboard of per-cycle expected phase/light/walk/ack words
module tb_intersection_phase_scheduler;
  import traffic_pkg::*;
  typedef struct packed {logic [2:0] ph; logic [1:0] ns, ew; logic w, a;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t obs;
  intersection_phase_scheduler_if bus();
  intersection_phase_scheduler #(
    .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_TIME(3), .ALLRED_TIME(2), .WALK_TIME(5), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign obs = {bus.phase, bus.light_ns, bus.light_ew, bus.walk, bus.ped_ack};
  always @(negedge clk)
    if (rst_n) begin
      total++;
      if ((bus.light_ns != RED && bus.light_ew != RED) ||
          (bus.walk && (bus.light_ns != RED || bus.light_ew != RED)) ||
          bus.light_ns == 2'b11 || bus.light_ew == 2'b11) begin
        bad++;
        $display("FAIL safety: ns=%b ew=%b walk=%b, need one road red, walk only in all-red, no 11",
                 bus.light_ns, bus.light_ew, bus.walk);
      end
    end
  task automatic push(input phase_t ph, input light_t ns, input light_t ew, input logic w,
                      input logic a, input int n);
    repeat (n) q.push_back({ph, ns, ew, w, a});
  endtask
  task automatic start(input logic cns, input logic cew);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.car_ns = cns;
    bus.car_ew = cew;
    bus.ped_req = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    exp_t e;
    bus.car_ns = 1'b0;
    bus.car_ew = 1'b0;
    bus.ped_req = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    push(ALLRED_INIT, RED, RED, 0, 0, 1);
    e = q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset: got %h need %h", obs, e);
    end
  endtask
  task automatic test_rest_in_green();
    exp_t e;
    start(0, 0);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 50);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL rest_in_green cyc %0d: got %h need %h", c, obs, e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_gap_out();
    exp_t e;
    start(0, 1);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 4);
    push(NS_YELLOW, YELLOW, RED, 0, 0, 3);
    push(ALLRED, RED, RED, 0, 0, 2);
    push(EW_GREEN, RED, GREEN, 0, 0, 6);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL gap_out cyc %0d: got %h need %h", c, obs, e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_max_out();
    exp_t e;
    start(1, 1);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    repeat (2) begin
      push(NS_GREEN, GREEN, RED, 0, 0, 10);
      push(NS_YELLOW, YELLOW, RED, 0, 0, 3);
      push(ALLRED, RED, RED, 0, 0, 2);
      push(EW_GREEN, RED, GREEN, 0, 0, 10);
      push(EW_YELLOW, RED, YELLOW, 0, 0, 3);
      push(ALLRED, RED, RED, 0, 0, 2);
    end
    push(NS_GREEN, GREEN, RED, 0, 0, 2);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL max_out cyc %0d: got %h need %h", c, obs, e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_ped_walk();
    exp_t e;
    start(0, 0);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 4);
    push(NS_YELLOW, YELLOW, RED, 0, 0, 3);
    push(ALLRED, RED, RED, 0, 0, 2);
    push(PED_WALK, RED, RED, 1, 1, 1);
    push(PED_WALK, RED, RED, 1, 0, 4);
    push(EW_GREEN, RED, GREEN, 0, 0, 6);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL ped_walk cyc %0d: got %h need %h", c, obs, e);
      end
      bus.ped_req = c == 3;
      @(negedge clk);
    end
  endtask
  // again=11 re-requests during ped_ack; again=10 collides with the walk-entry clear.
  task automatic test_back_to_back(input int again);
    exp_t e;
    start(0, 0);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 4);
    push(NS_YELLOW, YELLOW, RED, 0, 0, 3);
    push(ALLRED, RED, RED, 0, 0, 2);
    push(PED_WALK, RED, RED, 1, 1, 1);
    push(PED_WALK, RED, RED, 1, 0, 4);
    push(EW_GREEN, RED, GREEN, 0, 0, 4);
    push(EW_YELLOW, RED, YELLOW, 0, 0, 3);
    push(ALLRED, RED, RED, 0, 0, 2);
    push(PED_WALK, RED, RED, 1, 1, 1);
    push(PED_WALK, RED, RED, 1, 0, 4);
    push(NS_GREEN, GREEN, RED, 0, 0, 3);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back(%0d) cyc %0d: got %h need %h", again, c, obs, e);
      end
      bus.ped_req = c == 3 || c == again;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_in_yellow();
    exp_t e;
    start(0, 0);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 4);
    push(NS_YELLOW, YELLOW, RED, 0, 0, 2);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_in_yellow pre cyc %0d: got %h need %h", c, obs, e);
      end
      bus.ped_req = c == 3;
      if (c < 7) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    push(ALLRED_INIT, RED, RED, 0, 0, 1);
    e = q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_in_yellow async: got %h need %h", obs, e);
    end
    start(0, 0);
    push(ALLRED_INIT, RED, RED, 0, 0, 2);
    push(NS_GREEN, GREEN, RED, 0, 0, 20);
    for (int c = 0; q.size() > 0; c++) begin
      e = q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_in_yellow restart cyc %0d: got %h need %h", c, obs, e);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_rest_in_green();
    test_gap_out();
    test_max_out();
    test_ped_walk();
    test_back_to_back(11);
    test_back_to_back(10);
    test_reset_in_yellow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
